// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_serial
//  Description : Digit-serial adder/subtractor. Computes A+B or A-B over
//                WIDTH bits, DIGIT bits per clock, with a start/done
//                handshake and carry/overflow/zero/negative status flags.
//                Subtraction is performed as A + ~B + 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               cin_q, cin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               negative_q, negative_d;

    logic [DIGIT:0]     w_dsum;
    logic               w_msb_cin;
    logic [WIDTH-1:0]   w_acc_shift;
    logic [WIDTH-1:0]   w_a_shift;
    logic [WIDTH-1:0]   w_b_shift;

    // Digit adder: low DIGIT bits of both operands plus the running carry.
    always_comb begin
        w_dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, cin_q};
        // Carry into the top bit of this digit, recovered from its sum bit.
        // On the last compute cycle this is the carry into the result MSB.
        w_msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ w_dsum[DIGIT-1];
    end

    // Operand and partial-result shifting; a full-width digit needs no shift.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign w_acc_shift = w_dsum[DIGIT-1:0];
            assign w_a_shift   = '0;
            assign w_b_shift   = '0;
        end else begin : g_multi_digit
            assign w_acc_shift = {w_dsum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
            assign w_a_shift   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
            assign w_b_shift   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Next-state and datapath control; everything holds unless updated.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cin_d      = cin_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = mode ? ~b : b;
                    cin_d   = mode;     // the +1 of two's-complement negation
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = w_a_shift;
                b_d   = w_b_shift;
                acc_d = w_acc_shift;
                cin_d = w_dsum[DIGIT];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                    result_d   = w_acc_shift;
                    carry_d    = w_dsum[DIGIT];
                    overflow_d = w_dsum[DIGIT] ^ w_msb_cin;
                    zero_d     = (w_acc_shift == '0);
                    negative_d = w_acc_shift[WIDTH-1];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cin_q      <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cin_q      <= cin_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    // Outputs come straight from registers; no input-to-output path.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        result   = result_q;
        carry    = carry_q;
        overflow = overflow_q;
        zero     = zero_q;
        negative = negative_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_serial
//  Description : Self-checking bench for addsub_serial, two configurations
//                (8-bit/1-bit digits and 16-bit/4-bit digits) against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_serial;

    logic clk;
    logic rst_n;

    logic        start8, mode8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, carry8, ovf8, zero8, neg8;
    logic [7:0]  res8;

    logic        start16, mode16;
    logic [15:0] a16, b16;
    logic        busy16, done16, carry16, ovf16, zero16, neg16;
    logic [15:0] res16;

    int checks;
    int errors;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8),
        .carry(carry8), .overflow(ovf8), .zero(zero8), .negative(neg8)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .result(res16),
        .carry(carry16), .overflow(ovf16), .zero(zero16), .negative(neg16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {result[31:0], carry, overflow, zero, negative}.
    function automatic logic [35:0] model(input int w, input bit m,
                                          input longint unsigned a,
                                          input longint unsigned b);
        longint unsigned mask, r;
        longint          lim, sa, sb, sv;
        bit              c, ov, z, n;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        r    = m ? ((a - b) & mask) : ((a + b) & mask);
        c    = m ? (a >= b) : (((a + b) >> w) != 0);
        sa   = (a >= lim) ? longint'(a) - 2 * lim : longint'(a);
        sb   = (b >= lim) ? longint'(b) - 2 * lim : longint'(b);
        sv   = m ? (sa - sb) : (sa + sb);
        ov   = (sv < -lim) || (sv > lim - 1);
        z    = (r == 0);
        n    = ((r >> (w - 1)) & 1) != 0;
        return {r[31:0], c, ov, z, n};
    endfunction

    // Launch one 8-bit operation from idle and collect what it produced.
    // Called and returns at 1 time unit after a rising edge.
    task automatic do_op8(input bit m, input logic [7:0] a, input logic [7:0] b,
                          output logic [11:0] got, output int lat,
                          output int bcnt, output logic [1:0] after);
        start8 = 1'b1; mode8 = m; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat  = 0;
        bcnt = busy8 ? 1 : 0;
        got  = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (busy8) bcnt++;
            if (done8) begin
                lat = i;
                got = {res8, carry8, ovf8, zero8, neg8};
                break;
            end
        end
        @(posedge clk); #1;
        after = {busy8, done8};
    endtask

    task automatic do_op16(input bit m, input logic [15:0] a, input logic [15:0] b,
                           output logic [19:0] got, output int lat,
                           output int bcnt, output logic [1:0] after);
        start16 = 1'b1; mode16 = m; a16 = a; b16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat  = 0;
        bcnt = busy16 ? 1 : 0;
        got  = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (busy16) bcnt++;
            if (done16) begin
                lat = i;
                got = {res16, carry16, ovf16, zero16, neg16};
                break;
            end
        end
        @(posedge clk); #1;
        after = {busy16, done16};
    endtask

    task automatic test_reset;
        logic [12:0] o8;
        logic [20:0] o16;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o8  = {busy8, done8, res8, carry8, ovf8, zero8, neg8};
        o16 = {busy16, done16, res16, carry16, ovf16, zero16, neg16};
        checks++;
        if (o8 !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs8: got %h expected 0", o8);
        end
        checks++;
        if (o16 !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs16: got %h expected 0", o16);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed8;
        logic [11:0] got;
        int lat, bcnt;
        logic [1:0] after;
        logic [11:0] exp_tab [5];
        bit          m_tab   [5];
        logic [7:0]  a_tab   [5];
        logic [7:0]  b_tab   [5];
        m_tab[0] = 1; a_tab[0] = 8'h05; b_tab[0] = 8'h03; exp_tab[0] = {8'h02, 4'b1000};
        m_tab[1] = 1; a_tab[1] = 8'h03; b_tab[1] = 8'h05; exp_tab[1] = {8'hFE, 4'b0001};
        m_tab[2] = 1; a_tab[2] = 8'h80; b_tab[2] = 8'h01; exp_tab[2] = {8'h7F, 4'b1100};
        m_tab[3] = 0; a_tab[3] = 8'h7F; b_tab[3] = 8'h01; exp_tab[3] = {8'h80, 4'b0101};
        m_tab[4] = 0; a_tab[4] = 8'hFF; b_tab[4] = 8'h01; exp_tab[4] = {8'h00, 4'b1010};
        for (int i = 0; i < 5; i++) begin
            do_op8(m_tab[i], a_tab[i], b_tab[i], got, lat, bcnt, after);
            checks++;
            if (got !== exp_tab[i]) begin
                errors++;
                $display("FAIL directed8[%0d] {res,c,ov,z,n}: got %h expected %h",
                         i, got, exp_tab[i]);
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL directed8[%0d] latency: got %0d expected 8", i, lat);
            end
            checks++;
            if (bcnt !== 9 || after !== 2'b00) begin
                errors++;
                $display("FAIL directed8[%0d] busy_cycles/after: got %0d/%b expected 9/00",
                         i, bcnt, after);
            end
        end
    endtask

    task automatic test_random8;
        logic [11:0] got, exp;
        logic [35:0] e;
        int lat, bcnt;
        logic [1:0] after;
        bit m;
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            e = model(8, m, 64'(a), 64'(b));
            exp = e[11:0];
            do_op8(m, a, b, got, lat, bcnt, after);
            checks++;
            if (got !== exp || lat !== 8) begin
                errors++;
                $display("FAIL random8 m=%0d a=%h b=%h: got %h lat %0d expected %h lat 8",
                         m, a, b, got, lat, exp);
            end
        end
    endtask

    task automatic test_wide16;
        logic [19:0] got, exp;
        logic [35:0] e;
        int lat, bcnt;
        logic [1:0] after;
        bit m;
        logic [15:0] a, b;
        do_op16(1'b0, 16'h1234, 16'h0FFF, got, lat, bcnt, after);
        checks++;
        if (got !== {16'h2233, 4'b0000}) begin
            errors++;
            $display("FAIL wide16_directed {res,c,ov,z,n}: got %h expected %h",
                     got, {16'h2233, 4'b0000});
        end
        checks++;
        if (lat !== 4 || bcnt !== 5 || after !== 2'b00) begin
            errors++;
            $display("FAIL wide16_timing lat/busy/after: got %0d/%0d/%b expected 4/5/00",
                     lat, bcnt, after);
        end
        for (int i = 0; i < 30; i++) begin
            m = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 0) begin a = 16'h8000; b = 16'h0001; m = 1'b1; end
            if (i == 1) begin a = 16'h7FFF; b = 16'h7FFF; m = 1'b0; end
            e = model(16, m, 64'(a), 64'(b));
            exp = e[19:0];
            do_op16(m, a, b, got, lat, bcnt, after);
            checks++;
            if (got !== exp || lat !== 4) begin
                errors++;
                $display("FAIL random16 m=%0d a=%h b=%h: got %h lat %0d expected %h lat 4",
                         m, a, b, got, lat, exp);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [11:0] held, exp, cur;
        logic [35:0] e;
        int dones;
        held  = {res8, carry8, ovf8, zero8, neg8};
        e     = model(8, 1'b0, 64'h21, 64'h13);
        exp   = e[11:0];
        dones = 0;
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h21; b8 = 8'h13;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            cur = {res8, carry8, ovf8, zero8, neg8};
            if (done8) dones++;
            if (i < 8) begin
                checks++;
                if (cur !== held) begin
                    errors++;
                    $display("FAIL hold_during_run cycle %0d: got %h expected %h",
                             i, cur, held);
                end
            end
            if (i == 2) begin
                start8 = 1'b1; mode8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            end
            if (i == 3) start8 = 1'b0;
        end
        checks++;
        if (done8 !== 1'b1 || cur !== exp) begin
            errors++;
            $display("FAIL ignore_start_result done/res: got %b/%h expected 1/%h",
                     done8, cur, exp);
        end
        // Start pulse while in DONE must be lost.
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'h0F; b8 = 8'hF0;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done8) dones++;
            checks++;
            if (busy8 !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start_idle cycle %0d busy: got %b expected 0",
                         i, busy8);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_start_done_count: got %0d expected 1", dones);
        end
        cur = {res8, carry8, ovf8, zero8, neg8};
        checks++;
        if (cur !== exp) begin
            errors++;
            $display("FAIL ignore_start_final: got %h expected %h", cur, exp);
        end
    endtask

    task automatic test_reset_midrun;
        logic [12:0] o8;
        logic [11:0] got;
        int lat, bcnt, dones;
        logic [1:0] after;
        dones = 0;
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        o8 = {busy8, done8, res8, carry8, ovf8, zero8, neg8};
        checks++;
        if (o8 !== 13'h0) begin
            errors++;
            $display("FAIL reset_midrun_outputs: got %h expected 0", o8);
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        checks++;
        if (dones !== 0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun_no_done done_count/busy: got %0d/%b expected 0/0",
                     dones, busy8);
        end
        do_op8(1'b1, 8'h10, 8'h10, got, lat, bcnt, after);
        checks++;
        if (got !== {8'h00, 4'b1010} || lat !== 8) begin
            errors++;
            $display("FAIL reset_midrun_fresh_op: got %h lat %0d expected %h lat 8",
                     got, lat, {8'h00, 4'b1010});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start8 = 1'b0;  mode8 = 1'b0;  a8 = '0;  b8 = '0;
        start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
        test_reset();
        test_directed8();
        test_random8();
        test_wide16();
        test_ignore_start();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/addsub_serial.md
# addsub_serial

Parametrised sequential adder/subtractor for the FPGA controller datapath. Computes A+B or A−B over WIDTH bits, DIGIT bits per clock, with a start/done handshake and full status flags. It replaces the fixed 4-bit combinational subtractor wherever wider operands, add/subtract selection or a smaller area footprint are needed. Subtraction is A + ~B + 1, the same two's-complement scheme used throughout the design.

## Interface
Parameters:
- WIDTH, 8: operand and result width. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. Must be ≥ 1 and must divide WIDTH.
- Derived: N = WIDTH/DIGIT, the number of compute cycles.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a new operation; sampled only in IDLE.
- mode  in  1  operation select: 0 = A+B, 1 = A−B. Sampled together with start.
- a  in  WIDTH  operand A. Sampled together with start.
- b  in  WIDTH  operand B. Sampled together with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse marking a valid new result.
- result  out  WIDTH  sum or difference; registered.
- carry  out  1  carry out of the MSB. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, mode, and b (or ~b if mode=1). Set the internal carry to mode (1 for subtract, 0 for add). Clear the digit counter. Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - Add the lowest DIGIT bits of the A and B shift registers plus the internal carry.
  - Shift the DIGIT-bit sum into the partial-result register from the MSB end. Shift A and B right by DIGIT bits.
  - Update the internal carry and increment the counter.
- RUN exit: after the N-th compute cycle, go to DONE.
  - Load result from the partial register.
  - Load carry from the final carry out.
  - Load overflow = carry into MSB XOR carry out of MSB.
  - Load zero and negative from the final result.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing: a start pulse seen in those states is lost.
- result and the flags change only on the transition into DONE. They hold their values until the next completion, including during a following RUN.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset:
  - Asserting rst_n=0 immediately forces IDLE.
  - busy=0, done=0, result=0, carry=0, overflow=0, zero=0, negative=0.
  - Internal registers and the counter are cleared.
  - An in-flight operation is abandoned with no done pulse.
- Release of rst_n is synchronised by the system reset tree. No start is accepted in the first cycle after release.

## Timing
- start is sampled at rising edge k (state IDLE).
- busy is high from after edge k until edge k+N+1.
- Compute edges are k+1 … k+N.
- After edge k+N: DONE, done=1, result and flags valid.
- After edge k+N+1: IDLE, done=0, busy=0.
- Latency from the start edge to done high: N cycles. Throughput: one operation per N+2 cycles (the earliest new start is at edge k+N+2).
- With DIGIT=WIDTH: N=1, a one-cycle compute.
- There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=1, mode=1, a=0x05, b=0x03 -> result=0x02, carry=1, overflow=0, zero=0, negative=0. done rises exactly 8 cycles after the start edge.
- Same config, mode=1, a=0x03, b=0x05 -> result=0xFE, carry=0, negative=1, overflow=0. Then mode=1, a=0x80, b=0x01 -> result=0x7F, overflow=1, carry=1.
- mode=0, a=0x7F, b=0x01 -> result=0x80, overflow=1, negative=1, carry=0. Then mode=0, a=0xFF, b=0x01 -> result=0x00, carry=1, zero=1, overflow=0.
- WIDTH=16, DIGIT=4, mode=0, a=0x1234, b=0x0FFF -> result=0x2233, carry=0. done 4 cycles after start. busy high for 5 cycles.
- Pulse start with new operands during RUN and during DONE -> both ignored. result and flags stay unchanged until the original operation completes. done pulses exactly once.
- Assert rst_n=0 midway through RUN -> all outputs are 0 immediately and no done pulse occurs. After release, a fresh operation (mode=1, a=0x10, b=0x10) -> result=0x00, zero=1, carry=1.
